// File: rtl/simon_ctrl_v2_if.sv
// simon_ctrl_v2_if: game-side inputs and registered status
// of the Simon round controller.
interface simon_ctrl_v2_if #(
  parameter int SCORE_W = 4,
  parameter int LIVES_W = 2
);
  logic               simon_says;
  logic               sk_strobe;
  logic               round_passed;
  logic               sd_is_empty;
  logic               restart;
  logic               sd_srst;
  logic               fr_en;
  logic               mem_en;
  logic               is_wrong;
  logic               is_correct;
  logic               timed_out;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] best;
  logic [LIVES_W-1:0] lives_left;
  logic [2:0]         state;

  modport master (
    output simon_says, sk_strobe, round_passed,
    output sd_is_empty, restart,
    input  sd_srst, fr_en, mem_en,
    input  is_wrong, is_correct, timed_out,
    input  score, best, lives_left, state
  );

  modport slave (
    input  simon_says, sk_strobe, round_passed,
    input  sd_is_empty, restart,
    output sd_srst, fr_en, mem_en,
    output is_wrong, is_correct, timed_out,
    output score, best, lives_left, state
  );
endinterface

// File: rtl/simon_ctrl_v2.sv
// simon_ctrl_v2: Simon-says round controller with lives,
// score/best tracking and an idle timeout in PLAY.
module simon_ctrl_v2 #(
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 9,
  parameter int LIVES       = 3,
  parameter int LIVES_W     = 2,
  parameter int TIMEOUT_CYC = 1000,
  parameter int TO_W        = 16
) (
  input logic            clk,
  input logic            rst,
  simon_ctrl_v2_if.slave bus
);
  typedef enum logic [2:0] {
    READY = 3'd0,
    PLAY  = 3'd1,
    FAIL  = 3'd2,
    PASS  = 3'd3,
    WIN   = 3'd4,
    RETRY = 3'd5
  } st_t;

  localparam logic [SCORE_W-1:0] WIN_SC  = SCORE_W'(WIN_SCORE);
  localparam logic [LIVES_W-1:0] LIVES_I = LIVES_W'(LIVES);
  localparam logic [TO_W-1:0]    TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic               TO_ON   = (TIMEOUT_CYC != 0);

  st_t                state_q;
  logic               sd_srst_q;
  logic               fr_en_q;
  logic               mem_en_q;
  logic               is_wrong_q;
  logic               is_correct_q;
  logic               timed_out_q;
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] best_q;
  logic [LIVES_W-1:0] lives_q;
  logic [TO_W-1:0]    cnt_q;

  logic               in_play;
  logic               drain;
  logic               strobe;
  logic               expire;
  logic               miss;
  logic [SCORE_W-1:0] score_inc;

  // drain beats strobe beats timeout
  always_comb begin
    in_play   = (state_q == PLAY);
    drain     = in_play && !sd_srst_q && bus.sd_is_empty;
    strobe    = in_play && !drain && bus.sk_strobe;
    expire    = in_play && !drain && !bus.sk_strobe &&
                TO_ON && (cnt_q == TO_LAST);
    miss      = (drain && bus.simon_says && !bus.round_passed) ||
                (strobe && !bus.simon_says) || expire;
    score_inc = score_q + SCORE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= READY;
      sd_srst_q    <= 1'b1;
      fr_en_q      <= 1'b1;
      mem_en_q     <= 1'b1;
      is_wrong_q   <= 1'b0;
      is_correct_q <= 1'b0;
      timed_out_q  <= 1'b0;
      score_q      <= '0;
      best_q       <= '0;
      lives_q      <= LIVES_I;
      cnt_q        <= '0;
    end else begin
      unique case (state_q)
        READY: begin
          sd_srst_q <= 1'b0;
          mem_en_q  <= 1'b1;
          fr_en_q   <= 1'b1;
          if (bus.sd_is_empty) begin
            state_q      <= PLAY;
            mem_en_q     <= 1'b0;
            fr_en_q      <= 1'b0;
            sd_srst_q    <= 1'b1;
            is_correct_q <= 1'b0;
            cnt_q        <= '0;
          end
        end
        PLAY: begin
          fr_en_q <= 1'b0;
          if (!bus.sd_is_empty) sd_srst_q <= 1'b0;
          if (drain) begin
            sd_srst_q <= 1'b1;
          end else if (strobe) begin
            fr_en_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + TO_W'(1);
          end
          if (expire) timed_out_q <= 1'b1;
          if (miss) begin
            if (lives_q > LIVES_W'(1)) begin
              lives_q <= lives_q - LIVES_W'(1);
              state_q <= RETRY;
            end else begin
              lives_q    <= '0;
              is_wrong_q <= 1'b1;
              state_q    <= FAIL;
            end
          end else if (drain) begin
            state_q <= PASS;
          end
        end
        RETRY: begin
          sd_srst_q <= 1'b1;
          state_q   <= READY;
        end
        PASS: begin
          is_correct_q <= 1'b1;
          if (score_q == WIN_SC) begin
            state_q <= WIN;
          end else if (bus.sd_is_empty) begin
            sd_srst_q <= 1'b1;
          end else begin
            score_q   <= score_inc;
            sd_srst_q <= 1'b0;
            state_q   <= READY;
            if (score_inc > best_q) best_q <= score_inc;
          end
        end
        FAIL, WIN: begin
          if (bus.restart) begin
            state_q      <= READY;
            score_q      <= '0;
            lives_q      <= LIVES_I;
            is_wrong_q   <= 1'b0;
            is_correct_q <= 1'b0;
            timed_out_q  <= 1'b0;
            sd_srst_q    <= 1'b1;
          end
        end
        default: state_q <= READY;
      endcase
    end
  end

  assign bus.sd_srst    = sd_srst_q;
  assign bus.fr_en      = fr_en_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.is_wrong   = is_wrong_q;
  assign bus.is_correct = is_correct_q;
  assign bus.timed_out  = timed_out_q;
  assign bus.score      = score_q;
  assign bus.best       = best_q;
  assign bus.lives_left = lives_q;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_simon_ctrl_v2.sv
// tb_simon_ctrl_v2: scoreboard bench for the Simon controller,
// DUT built with an 8-cycle PLAY timeout.
`timescale 1ns/1ps
module tb_simon_ctrl_v2;
  localparam int SW = 4;
  localparam int LW = 2;

  localparam logic [2:0] S_READY = 3'd0;
  localparam logic [2:0] S_PLAY  = 3'd1;
  localparam logic [2:0] S_FAIL  = 3'd2;
  localparam logic [2:0] S_PASS  = 3'd3;
  localparam logic [2:0] S_WIN   = 3'd4;
  localparam logic [2:0] S_RETRY = 3'd5;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] sc;
    logic [3:0] bs;
    logic [1:0] lv;
    logic       w;
    logic       c;
    logic       t;
  } obs_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  int    n_cmp = 0;
  int    n_bad = 0;
  obs_t  exp_q[$];
  string nm_q[$];
  obs_t  g;
  obs_t  e;
  string nm;

  simon_ctrl_v2_if #(.SCORE_W(SW), .LIVES_W(LW)) bus ();

  simon_ctrl_v2 #(.TIMEOUT_CYC(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(logic [2:0] st, int sc, int bs,
                              int lv, logic w, logic c, logic t);
    obs_t o;
    o.st = st;
    o.sc = 4'(sc);
    o.bs = 4'(bs);
    o.lv = 2'(lv);
    o.w  = w;
    o.c  = c;
    o.t  = t;
    return o;
  endfunction

  function automatic obs_t now_obs();
    obs_t o;
    o = {bus.state, bus.score, bus.best, bus.lives_left,
         bus.is_wrong, bus.is_correct, bus.timed_out};
    return o;
  endfunction

  task automatic push(input string n, input obs_t x);
    exp_q.push_back(x);
    nm_q.push_back(n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // READY -> PLAY, then one idle cycle that clears sd_srst
  task automatic go_play();
    bus.sd_is_empty = 1'b1;
    tick();
    bus.sd_is_empty = 1'b0;
    tick();
  endtask

  task automatic play_round();
    go_play();
    bus.sd_is_empty  = 1'b1;
    bus.simon_says   = 1'b1;
    bus.round_passed = 1'b1;
    tick();
    bus.round_passed = 1'b0;
    bus.sd_is_empty  = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.restart = 1'b1;
    bus.sk_strobe = 1'b1;
    push("reset", mk(S_READY, 0, 0, 3, 0, 0, 0));
    tick();
    tick();
    e = exp_q.pop_front(); nm = nm_q.pop_front(); g = now_obs();
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, g, e);
    end
    n_cmp++;
    if ({bus.sd_srst, bus.fr_en, bus.mem_en} !== 3'b111) begin
      n_bad++;
      $display("FAIL reset_ctl: got %b want 111",
               {bus.sd_srst, bus.fr_en, bus.mem_en});
    end
    rst = 1'b1;
    bus.sk_strobe = 1'b0;
    push("ready_restart_ignored", mk(S_READY, 0, 0, 3, 0, 0, 0));
    tick();
    bus.restart = 1'b0;
    e = exp_q.pop_front(); nm = nm_q.pop_front(); g = now_obs();
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, g, e);
    end
    n_cmp++;
    if ({bus.sd_srst, bus.fr_en, bus.mem_en} !== 3'b011) begin
      n_bad++;
      $display("FAIL ready_ctl: got %b want 011",
               {bus.sd_srst, bus.fr_en, bus.mem_en});
    end
  endtask

  task automatic test_perfect_game();
    for (int r = 0; r < 10; r++) begin
      go_play();
      bus.sd_is_empty  = 1'b1;
      bus.simon_says   = 1'b1;
      bus.round_passed = 1'b1;
      push($sformatf("pg_pass%0d", r), mk(S_PASS, r, r, 3, 0, 0, 0));
      tick();
      bus.round_passed = 1'b0;
      e = exp_q.pop_front(); nm = nm_q.pop_front(); g = now_obs();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", nm, g, e);
      end
      if (r < 9) begin
        bus.sd_is_empty = 1'b0;
        push($sformatf("pg_next%0d", r),
             mk(S_READY, r + 1, r + 1, 3, 0, 1, 0));
        tick();
        e = exp_q.pop_front(); nm = nm_q.pop_front(); g = now_obs();
        n_cmp++;
        if (g !== e) begin
          n_bad++;
          $display("FAIL %s: got %h want %h", nm, g, e);
        end
      end
    end
    push("pg_win", mk(S_WIN, 9, 9, 3, 0, 1, 0));
    push("pg_win_hold", mk(S_WIN, 9, 9, 3, 0, 1, 0));
    for (int k = 0; k < 2; k++) begin
      tick();
      bus.sk_strobe   = (k == 0);
      bus.sd_is_empty = 1'b0;
      e = exp_q.pop_front(); nm = nm_q.pop_front(); g = now_obs();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", nm, g, e);
      end
    end
    bus.sk_strobe = 1'b0;
  endtask

  task automatic test_restart_win();
    bus.restart = 1'b1;
    push("restart_win", mk(S_READY, 0, 9, 3, 0, 0, 0));
    tick();
    bus.restart = 1'b0;
    e = exp_q.pop_front(); nm = nm_q.pop_front(); g = now_obs();
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, g, e);
    end
    n_cmp++;
    if (bus.sd_srst !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_srst: got %b want 1", bus.sd_srst);
    end
  endtask

  task automatic test_rst_mid_play();
    go_play();
    bus.restart = 1'b1;
    push("play_restart_ignored", mk(S_PLAY, 0, 9, 3, 0, 0, 0));
    tick();
    e = exp_q.pop_front(); nm = nm_q.pop_front(); g = now_obs();
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, g, e);
    end
    rst = 1'b0;
    bus.sk_strobe = 1'b1;
    push("rst_mid_play", mk(S_READY, 0, 0, 3, 0, 0, 0));
    tick();
    rst = 1'b1;
    bus.restart = 1'b0;
    bus.sk_strobe = 1'b0;
    e = exp_q.pop_front(); nm = nm_q.pop_front(); g = now_obs();
    n_cmp++;
    if (g !== e || {bus.sd_srst, bus.fr_en, bus.mem_en} !== 3'b111) begin
      n_bad++;
      $display("FAIL %s: got %h/%b want %h/111", nm, g,
               {bus.sd_srst, bus.fr_en, bus.mem_en}, e);
    end
  endtask

  task automatic test_miss_lives();
    for (int r = 0; r < 5; r++) play_round();
    push("five_rounds", mk(S_READY, 5, 5, 3, 0, 1, 0));
    e = exp_q.pop_front(); nm = nm_q.pop_front(); g = now_obs();
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, g, e);
    end
    for (int k = 1; k <= 3; k++) begin
      bus.restart = (k == 2);
      go_play();
      bus.simon_says = 1'b0;
      bus.sk_strobe  = 1'b1;
      if (k < 3) push($sformatf("miss%0d", k),
                      mk(S_RETRY, 5, 5, 3 - k, 0, 0, 0));
      else push("miss_fail", mk(S_FAIL, 5, 5, 0, 1, 0, 0));
      tick();
      bus.sk_strobe = 1'b0;
      bus.restart   = 1'b0;
      e = exp_q.pop_front(); nm = nm_q.pop_front(); g = now_obs();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", nm, g, e);
      end
      if (k < 3) push($sformatf("retry_ready%0d", k),
                      mk(S_READY, 5, 5, 3 - k, 0, 0, 0));
      else push("fail_hold", mk(S_FAIL, 5, 5, 0, 1, 0, 0));
      bus.sk_strobe = (k == 3);
      tick();
      bus.sk_strobe = 1'b0;
      e = exp_q.pop_front(); nm = nm_q.pop_front(); g = now_obs();
      n_cmp++;
      if (g !== e || (k < 3 && bus.sd_srst !== 1'b1)) begin
        n_bad++;
        $display("FAIL %s: got %h srst %b want %h", nm, g,
                 bus.sd_srst, e);
      end
    end
  endtask

  task automatic test_restart_fail();
    bus.restart = 1'b1;
    push("restart_fail", mk(S_READY, 0, 5, 3, 0, 0, 0));
    tick();
    bus.restart = 1'b0;
    e = exp_q.pop_front(); nm = nm_q.pop_front(); g = now_obs();
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, g, e);
    end
  endtask

  task automatic test_timeout();
    bus.simon_says = 1'b1;
    go_play();
    for (int i = 2; i <= 8; i++) begin
      if (i < 8) push($sformatf("idle%0d", i),
                      mk(S_PLAY, 0, 5, 3, 0, 0, 0));
      else push("timeout_miss", mk(S_RETRY, 0, 5, 2, 0, 0, 1));
      tick();
      e = exp_q.pop_front(); nm = nm_q.pop_front(); g = now_obs();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", nm, g, e);
      end
    end
    tick();
    go_play();
    for (int i = 2; i <= 6; i++) tick();
    bus.sk_strobe = 1'b1;
    push("strobe_7th", mk(S_PLAY, 0, 5, 2, 0, 0, 1));
    tick();
    bus.sk_strobe = 1'b0;
    e = exp_q.pop_front(); nm = nm_q.pop_front(); g = now_obs();
    n_cmp++;
    if (g !== e || bus.fr_en !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: got %h fr_en %b want %h fr_en 1", nm, g,
               bus.fr_en, e);
    end
    push("cleared_7_idle", mk(S_PLAY, 0, 5, 2, 0, 0, 1));
    for (int i = 0; i < 7; i++) tick();
    e = exp_q.pop_front(); nm = nm_q.pop_front(); g = now_obs();
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, g, e);
    end
    push("cleared_8th_miss", mk(S_RETRY, 0, 5, 1, 0, 0, 1));
    tick();
    e = exp_q.pop_front(); nm = nm_q.pop_front(); g = now_obs();
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, g, e);
    end
    tick();
  endtask

  task automatic test_drain_strobe();
    go_play();
    bus.sd_is_empty  = 1'b1;
    bus.sk_strobe    = 1'b1;
    bus.simon_says   = 1'b0;
    bus.round_passed = 1'b0;
    push("drain_over_strobe", mk(S_PASS, 0, 5, 1, 0, 0, 1));
    push("drain_next", mk(S_READY, 1, 5, 1, 0, 1, 1));
    for (int k = 0; k < 2; k++) begin
      tick();
      bus.sk_strobe   = 1'b0;
      bus.sd_is_empty = 1'b0;
      e = exp_q.pop_front(); nm = nm_q.pop_front(); g = now_obs();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", nm, g, e);
      end
    end
  endtask

  task automatic test_drain_miss_restart();
    go_play();
    bus.sd_is_empty  = 1'b1;
    bus.simon_says   = 1'b1;
    bus.round_passed = 1'b0;
    push("drain_miss_fail", mk(S_FAIL, 1, 5, 0, 1, 0, 1));
    tick();
    bus.sd_is_empty = 1'b0;
    e = exp_q.pop_front(); nm = nm_q.pop_front(); g = now_obs();
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, g, e);
    end
    bus.restart = 1'b1;
    push("restart_clears_to", mk(S_READY, 0, 5, 3, 0, 0, 0));
    tick();
    bus.restart = 1'b0;
    e = exp_q.pop_front(); nm = nm_q.pop_front(); g = now_obs();
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, g, e);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.simon_says   = 1'b0;
    bus.sk_strobe    = 1'b0;
    bus.round_passed = 1'b0;
    bus.sd_is_empty  = 1'b0;
    bus.restart      = 1'b0;
    test_reset();
    test_perfect_game();
    test_restart_win();
    test_rst_mid_play();
    test_miss_lives();
    test_restart_fail();
    test_timeout();
    test_drain_strobe();
    test_drain_miss_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
